// File: rtl/lm80c_kbd_pkg.sv
// rtl/lm80c_kbd_pkg.sv - shared types and constants for the LM80C PS/2 keyboard block
package lm80c_kbd_pkg;

    // Receiver frame position: start bit is consumed in IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    // Scancode prefixes.
    localparam logic [7:0] SC_RELEASE  = 8'hF0;
    localparam logic [7:0] SC_EXTEND   = 8'hE0;

    // Keyboard self-test / error bytes; any of them resets the matrix.
    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_ERR_LOW  = 8'h00;
    localparam logic [7:0] SC_ERR_HIGH = 8'hFF;

    // Key matrix geometry.
    localparam int ROW_W   = 3;
    localparam int COL_W   = 3;
    localparam int KM_ROWS = 1 << ROW_W;
    localparam int KM_COLS = 1 << COL_W;

    // True for bytes that release every key in the matrix.
    function automatic logic is_matrix_reset(input logic [7:0] b);
        return (b == SC_BAT_OK) || (b == SC_BAT_FAIL) ||
               (b == SC_ERR_LOW) || (b == SC_ERR_HIGH);
    endfunction

endpackage

// File: rtl/lm80c_keymap.sv
// rtl/lm80c_keymap.sv - combinational PS/2 set-2 scancode to LM80C matrix position lookup
module lm80c_keymap
    import lm80c_kbd_pkg::*;
(
    input  logic [7:0]       code,
    input  logic             ext,
    output logic             hit,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col
);

    // Table entries are {ext, code} -> {row, col} written as two octal digits.
    logic [ROW_W+COL_W-1:0] rc;

    // Lookup; extended and plain codes are distinct keys (E0 75 is not 75).
    always_comb begin
        hit = 1'b1;
        rc  = '0;
        case ({ext, code})
            // row 0: delete, return, right, function keys, left shift
            9'h066: rc = 6'o00;
            9'h05A: rc = 6'o01;
            9'h174: rc = 6'o02;
            9'h083: rc = 6'o03;
            9'h005: rc = 6'o04;
            9'h004: rc = 6'o05;
            9'h003: rc = 6'o06;
            9'h012: rc = 6'o07;
            // row 1: 3 W A 4 Z S E, down
            9'h026: rc = 6'o10;
            9'h01D: rc = 6'o11;
            9'h01C: rc = 6'o12;
            9'h025: rc = 6'o13;
            9'h01A: rc = 6'o14;
            9'h01B: rc = 6'o15;
            9'h024: rc = 6'o16;
            9'h172: rc = 6'o17;
            // row 2: 5 R D 6 C F T X
            9'h02E: rc = 6'o20;
            9'h02D: rc = 6'o21;
            9'h023: rc = 6'o22;
            9'h036: rc = 6'o23;
            9'h021: rc = 6'o24;
            9'h02B: rc = 6'o25;
            9'h02C: rc = 6'o26;
            9'h022: rc = 6'o27;
            // row 3: 7 Y G 8 B H U V
            9'h03D: rc = 6'o30;
            9'h035: rc = 6'o31;
            9'h034: rc = 6'o32;
            9'h03E: rc = 6'o33;
            9'h032: rc = 6'o34;
            9'h033: rc = 6'o35;
            9'h03C: rc = 6'o36;
            9'h02A: rc = 6'o37;
            // row 4: 9 I J 0 M K O N
            9'h046: rc = 6'o40;
            9'h043: rc = 6'o41;
            9'h03B: rc = 6'o42;
            9'h045: rc = 6'o43;
            9'h03A: rc = 6'o44;
            9'h042: rc = 6'o45;
            9'h044: rc = 6'o46;
            9'h031: rc = 6'o47;
            // row 5: = P L - . ; home ,
            9'h055: rc = 6'o50;
            9'h04D: rc = 6'o51;
            9'h04B: rc = 6'o52;
            9'h04E: rc = 6'o53;
            9'h049: rc = 6'o54;
            9'h04C: rc = 6'o55;
            9'h16C: rc = 6'o56;
            9'h041: rc = 6'o57;
            // row 6: right shift / left ctrl ' \ ` tab
            9'h059: rc = 6'o60;
            9'h04A: rc = 6'o61;
            9'h16B: rc = 6'o62;
            9'h014: rc = 6'o63;
            9'h052: rc = 6'o64;
            9'h05D: rc = 6'o65;
            9'h00E: rc = 6'o66;
            9'h00D: rc = 6'o67;
            // row 7: up 1 2 space Q esc right-ctrl delete
            9'h175: rc = 6'o70;
            9'h016: rc = 6'o71;
            9'h01E: rc = 6'o72;
            9'h029: rc = 6'o73;
            9'h015: rc = 6'o74;
            9'h076: rc = 6'o75;
            9'h114: rc = 6'o76;
            9'h171: rc = 6'o77;
            default: hit = 1'b0;
        endcase
    end

    assign row = rc[ROW_W+COL_W-1:COL_W];
    assign col = rc[COL_W-1:0];

endmodule

// File: rtl/lm80c_ps2_kbd.sv
// rtl/lm80c_ps2_kbd.sv - PS/2 keyboard receiver and scancode decoder driving the LM80C key matrix
module lm80c_ps2_kbd
    import lm80c_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 42000
)
(
    input  logic                             sys_clock,
    input  logic                             reset_n,
    input  logic                             ps2_clk,
    input  logic                             ps2_data,
    output logic [KM_ROWS-1:0][KM_COLS-1:0]  KM,
    output logic [7:0]                       code,
    output logic                             code_valid,
    output logic                             frame_err
);

    localparam int              TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    // ---------------- input synchronisers ----------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       fall_edge;
    logic       data_bit;

    // Two-flop synchronisers plus one history flop for edge detection; idle-high after reset.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall_edge = clk_prev_q & ~clk_sync_q[1];
    assign data_bit  = data_sync_q[1];

    // ---------------- receiver ----------------
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       code_q, code_d;
    logic             code_valid_q, code_valid_d;
    logic             frame_err_q, frame_err_d;

    // Receiver state, timeout counter and registered result pulses.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            timer_q      <= '0;
            code_q       <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            timer_q      <= timer_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Frame sequencing on PS/2 falling edges; a stalled frame is abandoned on timeout.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        // The counter only runs inside a frame and saturates so it cannot wrap.
        if (fall_edge || (state_q == ST_IDLE)) begin
            timer_d = '0;
        end else if (timer_q != TMR_LIMIT) begin
            timer_d = timer_q + TMR_W'(1);
        end else begin
            timer_d = timer_q;
        end

        if (fall_edge) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_bit;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if ((^{shift_q, parity_q}) && data_bit) begin
                        code_d       = shift_q;
                        code_valid_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q != ST_IDLE) && (timer_q == TMR_LIMIT)) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            shift_d     = '0;
            frame_err_d = 1'b1;
        end
    end

    // ---------------- decoder ----------------
    logic [KM_ROWS-1:0][KM_COLS-1:0] km_q, km_d;
    logic                            release_q, release_d;
    logic                            ext_q, ext_d;
    logic                            map_hit;
    logic [ROW_W-1:0]                map_row;
    logic [COL_W-1:0]                map_col;

    lm80c_keymap u_keymap (
        .code (code_q),
        .ext  (ext_q),
        .hit  (map_hit),
        .row  (map_row),
        .col  (map_col)
    );

    // Key matrix and prefix flags, updated the cycle after each received byte.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            km_q      <= '1;
            release_q <= 1'b0;
            ext_q     <= 1'b0;
        end else begin
            km_q      <= km_d;
            release_q <= release_d;
            ext_q     <= ext_d;
        end
    end

    // Prefix bytes only arm flags; any other byte consumes both flags.
    always_comb begin
        km_d      = km_q;
        release_d = release_q;
        ext_d     = ext_q;
        if (frame_err_q) begin
            release_d = 1'b0;
            ext_d     = 1'b0;
        end else if (code_valid_q) begin
            if (code_q == SC_RELEASE) begin
                release_d = 1'b1;
            end else if (code_q == SC_EXTEND) begin
                ext_d = 1'b1;
            end else begin
                if (is_matrix_reset(code_q)) begin
                    km_d = '1;
                end else if (map_hit) begin
                    km_d[map_row][map_col] = release_q;
                end
                release_d = 1'b0;
                ext_d     = 1'b0;
            end
        end
    end

    assign KM         = km_q;
    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_lm80c_ps2_kbd.sv
// tb/tb_lm80c_ps2_kbd.sv - self-checking bench for lm80c_ps2_kbd
module tb_lm80c_ps2_kbd;

    localparam int TB_TIMEOUT = 200;

    logic            sys_clock = 1'b0;
    logic            reset_n;
    logic            ps2_clk;
    logic            ps2_data;
    logic [7:0][7:0] KM;
    logic [7:0]      code;
    logic            code_valid;
    logic            frame_err;

    always #5 sys_clock = ~sys_clock;

    lm80c_ps2_kbd #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .KM         (KM),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int              cnt_cv = 0;
    int              cnt_fe = 0;
    logic            cv_d1  = 1'b0;
    logic [63:0]     km_at_cv;
    logic [63:0]     km_post_cv;
    logic [7:0]      last_code;

    logic [7:0][7:0] mkm;
    bit              mrel;
    bit              mext;
    logic [7:0]      mcode;
    int              half;

    always @(negedge sys_clock) begin
        if (cv_d1) km_post_cv = KM;
        cv_d1 = code_valid;
        if (code_valid) begin
            cnt_cv++;
            km_at_cv  = KM;
            last_code = code;
        end
        if (frame_err) cnt_fe++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic drive_bits(input logic [10:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            ps2_data = bits[i];
            wait_cyc(half);
            ps2_clk = 1'b0;
            wait_cyc(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Minimum mandated keymap; everything else used here is unmapped.
    function automatic bit model_lookup(input bit e, input logic [7:0] b, output int r, output int c);
        r = 0;
        c = 0;
        if (!e && b == 8'h1C) begin r = 1; c = 2; return 1'b1; end
        if (!e && b == 8'h12) begin r = 0; c = 7; return 1'b1; end
        if ( e && b == 8'h75) begin r = 7; c = 0; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int r, c;
        mcode = b;
        if (b == 8'hF0) mrel = 1'b1;
        else if (b == 8'hE0) mext = 1'b1;
        else begin
            if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) mkm = '1;
            else if (model_lookup(mext, b, r, c)) mkm[r][c] = mrel;
            mrel = 1'b0;
            mext = 1'b0;
        end
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int cv0, fe0;
        logic [63:0] km_before;
        cv0 = cnt_cv;
        fe0 = cnt_fe;
        km_before = mkm;
        drive_bits(make_frame(b, bad_par, bad_stop), 0, 10);
        wait_cyc(20);
        if (bad_par || bad_stop) begin
            mrel = 1'b0;
            mext = 1'b0;
            check("bad_cv_count", 64'(cnt_cv - cv0), 64'd0);
            check("bad_fe_count", 64'(cnt_fe - fe0), 64'd1);
            check("bad_km_kept", KM, km_before);
        end else begin
            model_byte(b);
            check("cv_count", 64'(cnt_cv - cv0), 64'd1);
            check("fe_count", 64'(cnt_fe - fe0), 64'd0);
            check("code_at_pulse", last_code, b);
            check("km_at_pulse", km_at_cv, km_before);
            check("km_one_after", km_post_cv, mkm);
            check("km_final", KM, mkm);
        end
        check("code_hold", code, mcode);
    endtask

    task automatic send(input logic [7:0] b);
        do_frame(b, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0]  q[$];
        int          cv0, fe0, ev;
        logic [10:0] bits;

        mkm   = '1;
        mrel  = 1'b0;
        mext  = 1'b0;
        mcode = 8'h00;
        half  = 25;

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check("rst_km", KM, {64{1'b1}});
        check("rst_code", code, 8'h00);
        check("rst_cv", code_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        reset_n = 1'b1;
        wait_cyc(5);

        send(8'h1C);
        check("a_press", KM, 64'hFFFFFFFF_FFFFFBFF);

        send(8'h12);
        send(8'hF0);
        send(8'h1C);
        check("shift_held", KM, 64'hFFFFFFFF_FFFFFF7F);

        do_frame(8'h1C, 1'b1, 1'b0);
        check("parity_rejected", KM, 64'hFFFFFFFF_FFFFFF7F);
        send(8'h1C);
        check("after_parity", KM, 64'hFFFFFFFF_FFFFFB7F);
        do_frame(8'h1C, 1'b0, 1'b1);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        check("all_released", KM, {64{1'b1}});

        send(8'hE0);
        send(8'h75);
        check("up_press", KM, 64'hFEFFFFFF_FFFFFFFF);
        send(8'hF0);
        send(8'hE0);
        send(8'h75);
        check("up_release_f0e0", KM, {64{1'b1}});
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("up_release_e0f0", KM, {64{1'b1}});
        send(8'h75);
        check("kp8_unmapped", KM, {64{1'b1}});

        send(8'h1C);
        send(8'h12);
        send(8'hFC);
        check("bat_clear", KM, {64{1'b1}});

        send(8'hE0);
        cv0 = cnt_cv;
        fe0 = cnt_fe;
        drive_bits(make_frame(8'h12, 1'b0, 1'b0), 0, 4);
        wait_cyc(TB_TIMEOUT + 60);
        mrel = 1'b0;
        mext = 1'b0;
        check("to_fe_count", 64'(cnt_fe - fe0), 64'd1);
        check("to_cv_count", 64'(cnt_cv - cv0), 64'd0);
        send(8'h12);
        check("after_timeout", KM, 64'hFFFFFFFF_FFFFFF7F);
        send(8'hF0);
        send(8'h12);

        send(8'h1C);
        bits = make_frame(8'h1C, 1'b0, 1'b0);
        drive_bits(bits, 0, 3);
        cv0 = cnt_cv;
        fe0 = cnt_fe;
        reset_n = 1'b0;
        wait_cyc(4);
        check("midrst_km", KM, {64{1'b1}});
        check("midrst_code", code, 8'h00);
        reset_n = 1'b1;
        wait_cyc(2);
        check("midrst_no_cv", 64'(cnt_cv - cv0), 64'd0);
        check("midrst_no_fe", 64'(cnt_fe - fe0), 64'd0);
        mkm   = '1;
        mrel  = 1'b0;
        mext  = 1'b0;
        mcode = 8'h00;
        drive_bits(bits, 4, 10);
        wait_cyc(TB_TIMEOUT + 60);
        check("stale_no_cv", 64'(cnt_cv - cv0), 64'd0);
        check("stale_km", KM, {64{1'b1}});
        send(8'h12);
        check("resume_after_rst", KM, 64'hFFFFFFFF_FFFFFF7F);

        for (int n = 0; n < 24; n++) begin
            q.delete();
            ev = $urandom_range(0, 7);
            case (ev)
                0: q.push_back(8'h1C);
                1: begin q.push_back(8'hF0); q.push_back(8'h1C); end
                2: q.push_back(8'h12);
                3: begin q.push_back(8'hF0); q.push_back(8'h12); end
                4: begin q.push_back(8'hE0); q.push_back(8'h75); end
                5: begin
                    if ($urandom_range(0, 1) == 0) begin
                        q.push_back(8'hE0); q.push_back(8'hF0);
                    end else begin
                        q.push_back(8'hF0); q.push_back(8'hE0);
                    end
                    q.push_back(8'h75);
                end
                6: begin
                    if ($urandom_range(0, 1) == 0) q.push_back(8'hF0);
                    q.push_back(8'h75);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: q.push_back(8'hAA);
                        1: q.push_back(8'hFC);
                        2: q.push_back(8'h00);
                        default: q.push_back(8'hFF);
                    endcase
                end
            endcase
            foreach (q[k]) begin
                half = $urandom_range(20, 32);
                if ($urandom_range(0, 9) == 0) begin
                    if ($urandom_range(0, 1) == 0) do_frame(q[k], 1'b1, 1'b0);
                    else do_frame(q[k], 1'b0, 1'b1);
                end
                send(q[k]);
                wait_cyc($urandom_range(0, 30));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
